// File: rtl/bdd_host_responder.sv
// Avalon-MM master that stands in for the HPS on the BDD request channel: polls
// requests, serves node fetches and find-or-insert from a local node table.
module bdd_host_responder #(
  parameter int ADDR_BITS = 10,
  parameter int VAR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 avm_read,
  input  logic [127:0]         avm_readdata,
  output logic                 avm_write,
  output logic [127:0]         avm_writedata,
  output logic [15:0]          avm_byteenable,
  input  logic                 avm_waitrequest,
  output logic                 done,
  output logic [29:0]          final_result,
  output logic [ADDR_BITS:0]   node_count,
  output logic                 table_full,
  output logic                 bad_index
);

  localparam int ENTRY_W = VAR_BITS + 60;
  localparam int DEPTH   = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] ONE = 1;
  localparam logic [ADDR_BITS:0] TWO = 2;

  typedef enum logic [2:0] {IDLE, RD, DEC, LKA, LKB, SCAN, INS, WR} state_t;

  state_t               state, stateN;
  logic [1:0]           reqType, reqTypeN;
  logic [29:0]          reqFinal, reqFinalN;
  logic [29:0]          reqA, reqAN;
  logic [29:0]          reqB, reqBN;
  logic [VAR_BITS-1:0]  reqVar, reqVarN;
  logic [63:0]          nodeA, nodeAN;
  logic                 lkValid, lkValidN;
  logic [ADDR_BITS:0]   scanPtr, scanPtrN;
  logic                 scanCmp, scanCmpN;
  logic [127:0]         wrDataN;
  logic                 doneN, tableFullN, badIndexN;
  logic [29:0]          finalN;
  logic [ADDR_BITS:0]   nodeCountN;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   rdData;
  logic [ADDR_BITS-1:0] memRAddr, memWAddr;
  logic                 memWe;
  logic [ENTRY_W-1:0]   memWData;

  logic [29:0]          countExt;
  logic [63:0]          lkNode;
  logic [ENTRY_W-1:0]   key;
  logic                 unusedRd;

  assign avm_byteenable = '1;
  assign countExt = 30'(node_count);
  assign lkNode   = lkValid ? {2'b00, rdData[59:30], 2'b00, rdData[29:0]} : '0;
  assign key      = {reqVar, reqA, reqB};
  assign unusedRd = ^{avm_readdata[63:62], avm_readdata[95:94], avm_readdata[127:96]};

  // Table port: one synchronous read per cycle, write only from INS.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= memWData;
    rdData <= mem[memRAddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      reqType       <= '0;
      reqFinal      <= '0;
      reqA          <= '0;
      reqB          <= '0;
      reqVar        <= '0;
      nodeA         <= '0;
      lkValid       <= 1'b0;
      scanPtr       <= '0;
      scanCmp       <= 1'b0;
      avm_writedata <= '0;
      done          <= 1'b0;
      final_result  <= '0;
      node_count    <= TWO;
      table_full    <= 1'b0;
      bad_index     <= 1'b0;
    end else begin
      state         <= stateN;
      reqType       <= reqTypeN;
      reqFinal      <= reqFinalN;
      reqA          <= reqAN;
      reqB          <= reqBN;
      reqVar        <= reqVarN;
      nodeA         <= nodeAN;
      lkValid       <= lkValidN;
      scanPtr       <= scanPtrN;
      scanCmp       <= scanCmpN;
      avm_writedata <= wrDataN;
      done          <= doneN;
      final_result  <= finalN;
      node_count    <= nodeCountN;
      table_full    <= tableFullN;
      bad_index     <= badIndexN;
    end
  end

  always_comb begin
    stateN     = state;
    reqTypeN   = reqType;
    reqFinalN  = reqFinal;
    reqAN      = reqA;
    reqBN      = reqB;
    reqVarN    = reqVar;
    nodeAN     = nodeA;
    lkValidN   = lkValid;
    scanPtrN   = scanPtr;
    scanCmpN   = scanCmp;
    wrDataN    = avm_writedata;
    doneN      = done;
    finalN     = final_result;
    nodeCountN = node_count;
    tableFullN = table_full;
    badIndexN  = bad_index;
    memRAddr   = '0;
    memWAddr   = '0;
    memWe      = 1'b0;
    memWData   = '0;
    avm_read   = 1'b0;
    avm_write  = 1'b0;

    case (state)
      IDLE: if (enable && !done) stateN = RD;

      RD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          reqTypeN  = avm_readdata[1:0];
          reqFinalN = avm_readdata[31:2];
          reqAN     = avm_readdata[61:32];
          reqBN     = avm_readdata[93:64];
          reqVarN   = avm_readdata[96 +: VAR_BITS];
          stateN    = DEC;
        end
      end

      DEC: begin
        case (reqType)
          2'b00, 2'b01: begin
            memRAddr = reqA[ADDR_BITS-1:0];
            lkValidN = (reqA >= 30'd2) && (reqA < countExt);
            if (reqA >= countExt) badIndexN = 1'b1;
            stateN   = LKA;
          end
          2'b10: begin
            if (reqA == reqB) begin
              wrDataN = {98'b0, reqB};
              stateN  = WR;
            end else begin
              scanPtrN = TWO;
              scanCmpN = 1'b0;
              stateN   = SCAN;
            end
          end
          default: begin
            finalN = reqFinal;
            doneN  = 1'b1;
            stateN = IDLE;
          end
        endcase
      end

      LKA: begin
        nodeAN = lkNode;
        if (reqType == 2'b00) begin
          wrDataN = {64'b0, lkNode};
          stateN  = WR;
        end else begin
          memRAddr = reqB[ADDR_BITS-1:0];
          lkValidN = (reqB >= 30'd2) && (reqB < countExt);
          if (reqB >= countExt) badIndexN = 1'b1;
          stateN   = LKB;
        end
      end

      LKB: begin
        wrDataN = {lkNode, nodeA};
        stateN  = WR;
      end

      // Address phase then compare phase per entry; only entries below node_count are scanned.
      SCAN: begin
        if (!scanCmp) begin
          if (scanPtr >= node_count) begin
            stateN = INS;
          end else begin
            memRAddr = scanPtr[ADDR_BITS-1:0];
            scanCmpN = 1'b1;
          end
        end else if (rdData == key) begin
          wrDataN = 128'(scanPtr);
          stateN  = WR;
        end else begin
          scanPtrN = scanPtr + ONE;
          scanCmpN = 1'b0;
        end
      end

      INS: begin
        if (!node_count[ADDR_BITS]) begin
          memWe      = 1'b1;
          memWAddr   = node_count[ADDR_BITS-1:0];
          memWData   = key;
          wrDataN    = 128'(node_count);
          nodeCountN = node_count + ONE;
        end else begin
          tableFullN = 1'b1;
          wrDataN    = '0;
        end
        stateN = WR;
      end

      WR: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) stateN = IDLE;
      end

      default: stateN = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bdd_host_responder.sv
// Bench for bdd_host_responder: acts as the request/response slave and checks
// responses and status against an array-based model of the node table.
module tb_bdd_host_responder;

  localparam int AB  = 2;
  localparam int CAP = 1 << AB;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         avm_read;
  logic [127:0] avm_readdata;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic         avm_waitrequest;
  logic         done;
  logic [29:0]  final_result;
  logic [AB:0]  node_count;
  logic         table_full;
  logic         bad_index;

  int checks = 0;
  int errors = 0;

  logic [15:0] mVar [CAP];
  logic [29:0] mT [CAP];
  logic [29:0] mE [CAP];
  int          mCount;
  bit          mFull;
  bit          mBad;

  bdd_host_responder #(.ADDR_BITS(AB), .VAR_BITS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .done(done), .final_result(final_result), .node_count(node_count),
    .table_full(table_full), .bad_index(bad_index)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    checks++;
    assert ((avm_read & avm_write) === 1'b0) else begin
      errors++;
      $error("FAIL rd_wr_exclusive observed=%b%b expected=0", avm_read, avm_write);
    end
  end

  function automatic logic [63:0] mNode(input logic [29:0] idx);
    if (int'(idx) >= mCount) mBad = 1'b1;
    if (idx < 30'd2 || int'(idx) >= mCount) return '0;
    return {2'b00, mT[idx], 2'b00, mE[idx]};
  endfunction

  function automatic logic [29:0] mFind(input logic [15:0] v, input logic [29:0] t, input logic [29:0] e);
    if (t == e) return e;
    for (int i = 2; i < mCount; i++)
      if (mVar[i] == v && mT[i] == t && mE[i] == e) return 30'(i);
    if (mCount < CAP) begin
      mVar[mCount] = v;
      mT[mCount]   = t;
      mE[mCount]   = e;
      mCount++;
      return 30'(mCount - 1);
    end
    mFull = 1'b1;
    return '0;
  endfunction

  // Slave side of one request/response exchange; called at a negedge.
  task automatic serve(input logic [127:0] word, input int rs, input int ws, input bit expWr,
                       input bit dropEn, output logic [127:0] resp, output int lat);
    int n;
    resp = '0;
    lat  = 0;
    n    = 0;
    while (avm_read !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("read_issued", 128'(avm_read), 128'(1));
    avm_readdata = word;
    for (int i = 0; i < rs; i++) begin
      @(negedge clk);
      check("read_held", 128'({avm_read, avm_write}), 128'(2'b10));
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    avm_waitrequest = 1'b1;
    avm_readdata    = {$urandom, $urandom, $urandom, $urandom};
    if (dropEn) enable = 1'b0;
    check("read_dropped", 128'(avm_read), 128'(0));
    if (expWr) begin
      n = 1;
      while (avm_write !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      lat = n;
      check("write_issued", 128'(avm_write), 128'(1));
      resp = avm_writedata;
      for (int i = 0; i < ws; i++) begin
        @(negedge clk);
        check("write_held", 128'({avm_write, avm_read}), 128'(2'b10));
        check("wdata_stable", avm_writedata, resp);
      end
      avm_waitrequest = 1'b0;
      @(negedge clk);
      avm_waitrequest = 1'b1;
      check("write_dropped", 128'(avm_write), 128'(0));
    end
  endtask

  task automatic doOp(input logic [1:0] ty, input logic [31:0] w1, input logic [31:0] w2,
                      input logic [31:0] w3, input int rs, input int ws, input bit dropEn,
                      output logic [127:0] resp);
    logic [127:0] word, exp;
    logic [63:0]  na, nb;
    int lat, expLat;
    word   = {w3, w2, w1, 30'b0, ty};
    expLat = -1;
    exp    = '0;
    case (ty)
      2'b00: begin exp = {64'b0, mNode(w1[29:0])}; expLat = 3; end
      2'b01: begin
        na = mNode(w1[29:0]);
        nb = mNode(w2[29:0]);
        exp = {nb, na};
        expLat = 4;
      end
      default: begin
        if (w1[29:0] == w2[29:0]) expLat = 2;
        exp = 128'(mFind(w3[15:0], w1[29:0], w2[29:0]));
      end
    endcase
    serve(word, rs, ws, 1'b1, dropEn, resp, lat);
    check("response", resp, exp);
    if (expLat >= 0) check("latency", 128'(lat), 128'(expLat));
    check("node_count", 128'(node_count), 128'(mCount));
    check("table_full", 128'(table_full), 128'(mFull));
    check("bad_index", 128'(bad_index), 128'(mBad));
    check("byteenable", 128'(avm_byteenable), 128'(16'hFFFF));
    if (dropEn) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("no_read_when_disabled", 128'(avm_read), 128'(0));
      end
      enable = 1'b1;
    end
  endtask

  initial begin
    logic [127:0] resp;
    int lat, n;
    reset = 1'b1;
    enable = 1'b0;
    avm_waitrequest = 1'b1;
    avm_readdata = '0;
    mCount = 2;
    mFull = 1'b0;
    mBad = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_read", 128'(avm_read), 128'(0));
    check("rst_write", 128'(avm_write), 128'(0));
    check("rst_wdata", avm_writedata, 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_final", 128'(final_result), 128'(0));
    check("rst_count", 128'(node_count), 128'(2));
    check("rst_full", 128'(table_full), 128'(0));
    check("rst_bad", 128'(bad_index), 128'(0));
    enable = 1'b1;

    doOp(2'b10, 32'd0, 32'd1, 32'd3, 0, 0, 1'b0, resp);
    check("first_insert", resp, 128'd2);
    doOp(2'b10, 32'd0, 32'd1, 32'd3, 0, 0, 1'b0, resp);
    check("repeat_insert", resp, 128'd2);
    doOp(2'b00, 32'd2, 32'd0, 32'd0, 0, 0, 1'b0, resp);
    check("one_node", resp, 128'h1);
    doOp(2'b10, 32'd2, 32'd1, 32'd4, 0, 0, 1'b0, resp);
    doOp(2'b01, 32'd2, 32'd3, 32'd0, 0, 0, 1'b0, resp);
    check("two_node", resp, {64'h0000_0002_0000_0001, 64'h1});
    doOp(2'b10, 32'd5, 32'd5, 32'd9, 0, 0, 1'b0, resp);
    check("reduced", resp, 128'd5);
    doOp(2'b10, 32'd1, 32'd2, 32'd7, 0, 0, 1'b0, resp);
    check("full_insert", resp, 128'd0);
    check("full_flag", 128'(table_full), 128'(1));
    doOp(2'b00, 32'd9, 32'd0, 32'd0, 0, 0, 1'b0, resp);
    check("bad_fetch", resp, 128'd0);
    check("bad_flag", 128'(bad_index), 128'(1));
    doOp(2'b01, 32'd3, 32'd2, 32'd0, 10, 10, 1'b0, resp);
    doOp(2'b00, 32'd3, 32'd0, 32'd0, 1, 2, 1'b1, resp);

    // Reset while a read is stalled: the request is dropped, table contents stay stale.
    n = 0;
    while (avm_read !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("read_before_reset", 128'(avm_read), 128'(1));
    avm_readdata = {96'b0, 32'h2};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_read_drop", 128'(avm_read), 128'(0));
    check("reset_count", 128'(node_count), 128'(2));
    check("reset_flags", 128'({table_full, bad_index, done}), 128'(0));
    mCount = 2;
    mFull = 1'b0;
    mBad = 1'b0;

    for (int k = 0; k < 60; k++) begin
      logic [1:0] ty;
      logic [31:0] w1, w2, w3;
      ty = 2'($urandom_range(2));
      if (ty == 2'b10) begin
        w1 = 32'($urandom_range(3)) | (32'($urandom_range(3)) << 30);
        w2 = 32'($urandom_range(3)) | (32'($urandom_range(3)) << 30);
        w3 = 32'($urandom_range(2)) | (32'($urandom_range(255)) << 16);
      end else begin
        w1 = 32'($urandom_range(5)) | (32'($urandom_range(3)) << 30);
        w2 = 32'($urandom_range(5)) | (32'($urandom_range(3)) << 30);
        w3 = $urandom;
      end
      doOp(ty, w1, w2, w3, $urandom_range(2), $urandom_range(2), 1'b0, resp);
    end

    serve({96'b0, 30'd7, 2'b11}, 0, 0, 1'b0, 1'b0, resp, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_after_finish", 128'({avm_read, avm_write}), 128'(0));
    end
    check("done", 128'(done), 128'(1));
    check("final_result", 128'(final_result), 128'(7));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bdd_host_responder.md
Name: bdd_host_responder

Overview:
- Hardware stand-in for the HPS on the BDD coprocessor request channel: an Avalon-MM master that services requests from the 128-bit request/response slave.
- Loop: poll-read a request word, decode it, service it from a local node table (apply node fetch, find-or-insert, finish), write the 128-bit response back.
- Allows full-FPGA BDD runs and closed-loop verification without the HPS; sits where the HPS bridge would connect.

Parameters:
- ADDR_BITS, 10, log2 node-table depth. Indices 0 and 1 are reserved terminals; inserts start at 2.
- VAR_BITS, 16, stored variable width; the low VAR_BITS of request word 3 are used.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  level; responder issues new reads only while high
- avm_read  out  1  Avalon read request
- avm_readdata  in  128  request word
- avm_write  out  1  Avalon write request
- avm_writedata  out  128  response word
- avm_byteenable  out  16  constant 16'hFFFF
- avm_waitrequest  in  1  slave stall
- done  out  1  sticky; set on FINISHED request
- final_result  out  30  index carried in FINISHED request
- node_count  out  ADDR_BITS+1  allocated entries, including terminals
- table_full  out  1  sticky; insert attempted with a full table
- bad_index  out  1  sticky; fetch of index >= node_count

Behaviour:
- Reset values: avm_read=0, avm_write=0, avm_writedata=0, done=0, final_result=0, node_count=2, table_full=0, bad_index=0, FSM=IDLE. Table contents are not cleared; only entries below node_count are valid.
- Request format:
  - [1:0] type: 00 one-node apply, 01 two-node apply, 10 find-or-insert, 11 finished.
  - Apply: [63:32] index A, [95:64] index B.
  - Find-or-insert: [63:32] t, [95:64] e, [127:96] var.
  - Finished: [31:2] final index.
  - Indices use the low 30 bits of each word.
- Node packing (64 bits): [61:32] = t (v-child), [29:0] = e (nv-child), other bits 0.
- Response format:
  - One-node: node(A) in bits [63:0].
  - Two-node: node(A) in [63:0], node(B) in [127:64].
  - Find-or-insert: result index in [29:0], rest 0.
  - Finished: no write.
- Avalon rules:
  - avm_read and avm_write are held high, with data stable, until the cycle avm_waitrequest=0.
  - That cycle is the accept; the strobe drops on the next cycle.
  - avm_readdata is sampled on the read-accept cycle.
  - avm_read and avm_write are never high together.
- FSM:
  - IDLE: go to RD when enable=1 and done=0.
  - RD: assert read; on accept, latch word and go to DEC.
  - DEC: dispatch on type.
    - Apply: issue table read of A, go to LKA.
    - Find-or-insert with t==e: result=e, go to WR (reduction rule, no insert).
    - Find-or-insert otherwise: scan pointer=2, go to SCAN.
    - Finished: latch final_result, set done, go to IDLE.
  - LKA: table read has 1-cycle latency; capture node(A). One-node: go to WR. Two-node: read B, go to LKB.
  - LKB: capture node(B), go to WR.
  - SCAN: 2 cycles per entry (address, then compare of {var,t,e}).
    - Hit: result=pointer, go to WR.
    - Pointer reaches node_count: go to INS.
  - INS:
    - If node_count < 2^ADDR_BITS: write entry at node_count, result=node_count, increment node_count.
    - Else: set table_full, result=0.
    - Then go to WR.
  - WR: assert write; on accept, go to IDLE.
- Lookup of an index >= node_count, or of index 0/1, returns a zero node. An out-of-range index (>= node_count) also sets bad_index.
- Latency:
  - One-node: write asserted 3 cycles after read accept.
  - Two-node: 4 cycles after read accept.
  - Reduced find-or-insert: 2 cycles after read accept.
- enable falling mid-transaction: the current request completes; the next read is not issued.
- Reset mid-transaction: strobes drop on the next cycle; the in-flight request is lost.

Test Plan:
- Find-or-insert (var=3, t=0, e=1) on empty table → writedata[29:0]=2, node_count=3. Repeat same request → result 2, node_count stays 3.
- Insert (3,0,1) then one-node apply A=2 → writedata[63:0]=64'h0000_0000_0000_0001. Write is asserted exactly 3 cycles after read accept.
- Two-node apply A=2, B=3 after inserting (4,2,1) → [63:0]=node(2), [127:64]=64'h0000_0002_0000_0001.
- Find-or-insert t=e=5 → response 5, no table change. Finished with [31:2]=7 → done=1, final_result=7, no further reads.
- avm_waitrequest held high 10 cycles on read and on write → strobes and writedata stable throughout, single accept each.
- ADDR_BITS=2: fill to node_count=4, then a new unique insert → table_full=1, response 0. Fetch of index 9 → bad_index=1, zero node returned.
